// File: rtl/spm_seq_ctrl.sv
// Sequencer for the serial-parallel multiplier spm: accepts an operand pair, streams the
// multiplier LSB-first (sign-extended to 2*SIZE bits) and deserialises spm_p into a product.
module spm_seq_ctrl #(
   parameter int SIZE  = 32,
   parameter int CNT_W = $clog2(2*SIZE+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [SIZE-1:0]   in_a,
   input  logic [SIZE-1:0]   in_b,
   output logic              spm_rst,
   output logic [SIZE-1:0]   spm_x,
   output logic              spm_y,
   input  logic              spm_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*SIZE-1:0] out_prod,
   output logic              busy
);

   localparam int PW = 2*SIZE;
   localparam logic [CNT_W-1:0] C_SIZE = CNT_W'(SIZE);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PW);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [SIZE-1:0]   r_b_sh;
   logic              r_sign;
   logic [PW-1:0]     r_prod_sh;
   logic [PW-1:0]     r_out_prod;
   logic [SIZE-1:0]   r_spm_x;
   logic              r_spm_rst;
   logic              r_out_valid;
   logic              w_spm_y;
   logic [PW-1:0]     w_prod_nxt;

   assign w_prod_nxt = {spm_p, r_prod_sh[PW-1:1]};

   always_comb begin
      w_next  = r_state;
      w_spm_y = 1'b0;
      case (r_state)
         S_IDLE:  if (in_valid) w_next = S_CLEAR;
         S_CLEAR: w_next = S_SHIFT;
         S_SHIFT: begin
            // Above the operand width the multiplier is its own sign bit.
            w_spm_y = (r_cnt < C_SIZE) ? r_b_sh[0] : r_sign;
            if (r_cnt == C_LAST) w_next = S_DONE;
         end
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_b_sh      <= '0;
         r_sign      <= 1'b0;
         r_prod_sh   <= '0;
         r_out_prod  <= '0;
         r_spm_x     <= '0;
         r_spm_rst   <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_spm_rst   <= (w_next != S_SHIFT);
         r_out_valid <= (w_next == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_spm_x <= in_a;
                  r_b_sh  <= in_b;
                  r_sign  <= in_b[SIZE-1];
               end
            end
            S_CLEAR: begin
               r_cnt     <= '0;
               r_prod_sh <= '0;
            end
            S_SHIFT: begin
               r_b_sh <= {1'b0, r_b_sh[SIZE-1:1]};
               if (r_cnt != C_LAST) r_cnt <= r_cnt + 1'b1;
               // spm registers its output, so the bit seen at count k is product bit k-1.
               if (r_cnt != '0) r_prod_sh <= w_prod_nxt;
               if (r_cnt == C_LAST) r_out_prod <= w_prod_nxt;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state == S_CLEAR) || (r_state == S_SHIFT);
   assign spm_rst   = r_spm_rst;
   assign spm_x     = r_spm_x;
   assign spm_y     = w_spm_y;
   assign out_valid = r_out_valid;
   assign out_prod  = r_out_prod;

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Bench for spm_seq_ctrl at SIZE=4 and SIZE=32, each driving a behavioural spm; products
// are compared against signed multiplication of the operands.
module tb_spm_seq_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // SIZE=4 instance
   logic       in_valid4, in_ready4, spm_rst4, spm_y4, spm_p4, out_valid4, out_ready4, busy4;
   logic [3:0] in_a4, in_b4, spm_x4;
   logic [7:0] out_prod4;

   spm_seq_ctrl #(.SIZE(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_a(in_a4), .in_b(in_b4), .spm_rst(spm_rst4), .spm_x(spm_x4),
      .spm_y(spm_y4), .spm_p(spm_p4), .out_valid(out_valid4),
      .out_ready(out_ready4), .out_prod(out_prod4), .busy(busy4)
   );

   // SIZE=32 instance
   logic        in_valid32, in_ready32, spm_rst32, spm_y32, spm_p32, out_valid32, out_ready32, busy32;
   logic [31:0] in_a32, in_b32, spm_x32;
   logic [63:0] out_prod32;

   spm_seq_ctrl #(.SIZE(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
      .in_a(in_a32), .in_b(in_b32), .spm_rst(spm_rst32), .spm_x(spm_x32),
      .spm_y(spm_y32), .spm_p(spm_p32), .out_valid(out_valid32),
      .out_ready(out_ready32), .out_prod(out_prod32), .busy(busy32)
   );

   // Behavioural spm: accumulates y_j * x * 2^j and emits product bit j one edge after y_j.
   logic [7:0]  m4_acc, m4_t;
   int          m4_j;
   always @(posedge clk or posedge rst) begin
      if (rst || spm_rst4) begin
         m4_acc <= '0; m4_j <= 0; spm_p4 <= 1'b0;
      end else begin
         m4_t = m4_acc + (spm_y4 ? ({{4{spm_x4[3]}}, spm_x4} << m4_j) : 8'd0);
         m4_acc <= m4_t;
         spm_p4 <= (m4_j < 8) ? m4_t[m4_j[2:0]] : 1'b0;
         m4_j   <= m4_j + 1;
      end
   end

   logic [63:0] m32_acc, m32_t;
   int          m32_j;
   always @(posedge clk or posedge rst) begin
      if (rst || spm_rst32) begin
         m32_acc <= '0; m32_j <= 0; spm_p32 <= 1'b0;
      end else begin
         m32_t = m32_acc + (spm_y32 ? ({{32{spm_x32[31]}}, spm_x32} << m32_j) : 64'd0);
         m32_acc <= m32_t;
         spm_p32 <= (m32_j < 64) ? m32_t[m32_j[5:0]] : 1'b0;
         m32_j   <= m32_j + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b);
      return $signed(a) * $signed(b);
   endfunction

   function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b);
      return $signed(a) * $signed(b);
   endfunction

   task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input int hold);
      int k;
      int lat;
      int errs;
      logic [7:0] held;
      k = 0;
      while (!in_ready4 && k < 50) begin step(); k++; end
      check("rdy4", in_ready4, 1);
      in_valid4 = 1'b1; in_a4 = a; in_b4 = b;
      step();
      check("accept4", busy4, 1);
      // Source keeps presenting other data; none of it may be taken.
      in_a4 = 4'($urandom); in_b4 = 4'($urandom);
      lat = 0; errs = 0;
      while (!out_valid4 && lat < 100) begin
         if (spm_x4 !== a || in_ready4 !== 1'b0 || spm_rst4 !== (lat == 0)) errs++;
         step(); lat++;
      end
      check("lat4", lat, 10);
      check("busy_ctl4", errs, 0);
      check("prod4", out_prod4, ref4(a, b));
      check("done4", {busy4, in_ready4, spm_rst4}, 3'b001);
      out_ready4 = 1'b0;
      held = out_prod4; errs = 0;
      repeat (hold) begin
         step();
         if (out_prod4 !== held || in_ready4 !== 1'b0 || out_valid4 !== 1'b1) errs++;
      end
      check("hold4", errs, 0);
      out_ready4 = 1'b1;
      step();
      check("release4", {in_ready4, out_valid4, busy4}, 3'b100);
      in_valid4 = 1'b0; out_ready4 = 1'b0;
   endtask

   task automatic run_op32(input logic [31:0] a, input logic [31:0] b);
      int k;
      int lat;
      k = 0;
      while (!in_ready32 && k < 50) begin step(); k++; end
      check("rdy32", in_ready32, 1);
      in_valid32 = 1'b1; in_a32 = a; in_b32 = b;
      step();
      in_valid32 = 1'b0;
      lat = 0;
      while (!out_valid32 && lat < 200) begin step(); lat++; end
      check("lat32", lat, 66);
      check("prod32", out_prod32, ref32(a, b));
      out_ready32 = 1'b1;
      step();
      out_ready32 = 1'b0;
      check("release32", out_valid32, 0);
   endtask

   logic [3:0] pa[3];
   logic [3:0] pb[3];
   logic [7:0] expq[$];

   initial begin
      int idx;
      int got;
      logic acc;
      rst = 1'b1;
      in_valid4 = 0; in_a4 = 0; in_b4 = 0; out_ready4 = 0;
      in_valid32 = 0; in_a32 = 0; in_b32 = 0; out_ready32 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctl4", {in_ready4, spm_rst4, spm_y4, out_valid4, busy4}, 5'b11000);
      check("rst_x4", spm_x4, 0);
      check("rst_prod4", out_prod4, 0);
      check("rst_ctl32", {in_ready32, spm_rst32, out_valid32, busy32, |out_prod32}, 5'b11000);
      rst = 1'b0;
      step();

      run_op4(4'd3, 4'd5, 0);
      run_op4(4'h8, 4'h8, 0);
      run_op4(4'h8, 4'd7, 20);
      for (int i = 0; i < 12; i++)
         run_op4(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));

      run_op32(32'hFFFFFFFF, 32'h7FFFFFFF);
      run_op32(32'd0, $urandom);
      for (int i = 0; i < 3; i++) run_op32($urandom, $urandom);

      // Back-to-back with in_valid held high and the consumer always ready.
      pa[0] = 4'h8; pb[0] = 4'h8;
      pa[1] = 4'h0; pb[1] = 4'h5;
      pa[2] = 4'($urandom); pb[2] = 4'($urandom);
      idx = 0; got = 0;
      in_valid4 = 1'b1; in_a4 = pa[0]; in_b4 = pb[0]; out_ready4 = 1'b1;
      for (int cyc = 0; cyc < 200 && got < 3; cyc++) begin
         acc = in_ready4 && in_valid4;
         if (out_valid4) begin
            check("b2b_prod", out_prod4, (expq.size() > 0) ? expq.pop_front() : 8'hxx);
            got++;
         end
         step();
         if (acc) begin
            check("b2b_clear", spm_rst4, 1);
            expq.push_back(ref4(pa[idx], pb[idx]));
            idx++;
            if (idx < 3) begin in_a4 = pa[idx]; in_b4 = pb[idx]; end
            else in_valid4 = 1'b0;
         end
      end
      check("b2b_count", got, 3);
      in_valid4 = 1'b0; out_ready4 = 1'b0;
      step();

      // Asynchronous reset in the middle of SHIFT (count 5).
      in_valid4 = 1'b1; in_a4 = 4'd7; in_b4 = 4'd7;
      step();
      in_valid4 = 1'b0;
      repeat (6) step();
      check("pre_rst_busy", busy4, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_ctl4", {in_ready4, spm_rst4, spm_y4, out_valid4, busy4}, 5'b11000);
      check("arst_x4", spm_x4, 0);
      check("arst_prod4", out_prod4, 0);
      #1 rst = 1'b0;
      run_op4(4'd2, 4'hD, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
